// File: rtl/gpio_seq_ctrl_if.sv
// AHB-Lite link between the GPIO sequencer (master) and the GPIO peripheral (slave).
interface gpio_seq_ctrl_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        PARITYERR;

  modport master (
    output HADDR, HTRANS, HWRITE, HWDATA, HSEL,
    input  HREADY, HRDATA, PARITYERR
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HWDATA, HSEL,
    output HREADY, HRDATA, PARITYERR
  );
endinterface

// File: rtl/gpio_seq_ctrl.sv
// Turns valid/ready GPIO requests into ordered AHB direction/data transfers.
// Build option GPIO_SEQ_VERIFY_EN adds a readback after every data write.
module gpio_seq_ctrl #(
  parameter logic [31:0] GPIO_DATA_ADDR = 32'h0000_0000,
  parameter logic [31:0] GPIO_DIR_ADDR  = 32'h0000_0004,
  parameter int unsigned SETTLE_CYCLES  = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // A request moves on the edge where req_valid && req_ready; a response
  // retires on the edge where rsp_valid && rsp_ready and is held stable until then.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [16:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        rsp_mismatch,
  gpio_seq_ctrl_if.master ahb,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_DIR_A, S_DIR_D, S_SETTLE, S_DAT_A, S_DAT_D, S_RD_A, S_RD_D, S_RESP
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        dir_q, wr_q;
  logic [15:0] wdata_q;
  logic [3:0]  settle_q;
  logic        req_ready_q, rsp_valid_q, rsp_perr_q;
  logic [16:0] rsp_rdata_q;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d, hsel_q, hsel_d;
  logic        unused_hrdata;

  assign unused_hrdata = ^ahb.HRDATA[31:17];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (req_write != dir_q) state_d = S_DIR_A;
        else if (req_write)     state_d = S_DAT_A;
        else                    state_d = S_RD_A;
      end
      S_DIR_A:  if (ahb.HREADY) state_d = S_DIR_D;
      S_DIR_D:  if (ahb.HREADY) state_d = wr_q ? S_DAT_A : ((SETTLE_CYCLES == 0) ? S_RD_A : S_SETTLE);
      S_SETTLE: if (settle_q == 4'd0) state_d = S_RD_A;
      S_DAT_A:  if (ahb.HREADY) state_d = S_DAT_D;
`ifdef GPIO_SEQ_VERIFY_EN
      S_DAT_D:  if (ahb.HREADY) state_d = S_RD_A;
`else
      S_DAT_D:  if (ahb.HREADY) state_d = S_RESP;
`endif
      S_RD_A:   if (ahb.HREADY) state_d = S_RD_D;
      S_RD_D:   if (ahb.HREADY) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they come straight off flops.
  // Address and direction are held through the data phase; HWDATA only there.
  always_comb begin
    haddr_d  = '0;
    htrans_d = 2'b00;
    hwrite_d = 1'b0;
    hwdata_d = '0;
    hsel_d   = 1'b0;
    case (state_d)
      S_DIR_A: begin hsel_d = 1'b1; htrans_d = 2'b10; haddr_d = GPIO_DIR_ADDR; hwrite_d = 1'b1; end
      S_DIR_D: begin haddr_d = GPIO_DIR_ADDR; hwrite_d = 1'b1; hwdata_d = {31'h0, wr_q}; end
      S_DAT_A: begin hsel_d = 1'b1; htrans_d = 2'b10; haddr_d = GPIO_DATA_ADDR; hwrite_d = 1'b1; end
      S_DAT_D: begin haddr_d = GPIO_DATA_ADDR; hwrite_d = 1'b1; hwdata_d = {16'h0, wdata_q}; end
      S_RD_A:  begin hsel_d = 1'b1; htrans_d = 2'b10; haddr_d = GPIO_DATA_ADDR; end
      S_RD_D:  begin haddr_d = GPIO_DATA_ADDR; end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      settle_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= 2'b00;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      hsel_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      hsel_q      <= hsel_d;
      if (state_q == S_IDLE && req_valid) begin
        wr_q        <= req_write;
        wdata_q     <= req_wdata;
        rsp_rdata_q <= '0;
        rsp_perr_q  <= 1'b0;
      end
      if (state_q == S_DIR_D && ahb.HREADY) begin
        dir_q    <= wr_q;
        settle_q <= SETTLE_LOAD;
      end
      if (state_q == S_SETTLE && settle_q != 4'd0) settle_q <= settle_q - 4'd1;
      if (state_q == S_RD_D && ahb.HREADY) begin
        rsp_rdata_q <= ahb.HRDATA[16:0];
        rsp_perr_q  <= ahb.PARITYERR;
      end
    end
  end

`ifdef GPIO_SEQ_VERIFY_EN
  logic rsp_mismatch_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_mismatch_q <= 1'b0;
    end else if (state_q == S_IDLE && req_valid) begin
      rsp_mismatch_q <= 1'b0;
    end else if (state_q == S_RD_D && ahb.HREADY && wr_q) begin
      rsp_mismatch_q <= (ahb.HRDATA[15:0] != wdata_q);
    end
  end

  assign rsp_mismatch = rsp_mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_perr   = rsp_perr_q;
  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HWDATA = hwdata_q;
  assign ahb.HSEL   = hsel_q;
  assign dbg_state  = state_q;

endmodule
